sub8_serial: RTL and testbench
==============================

# sub8_serial

Bit-serial 8-bit subtractor computing a − b − borrow_in one bit per clock, LSB first, with the same flag set as the 8-bit adder: sign, signed overflow and borrow-out. It is the subtract-direction counterpart to the combinational adder. It sits in area-constrained datapaths where an 8-bit result can arrive over multiple cycles behind a start/done handshake.

## Interface
Parameters:
- none. Width is fixed at 8.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- a  input  8  minuend; captured when start is accepted.
- b  input  8  subtrahend; captured when start is accepted.
- borrow_in  input  1  incoming borrow; captured when start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; the result outputs are valid from this cycle.
- c  output  8  difference, modulo 256 (saturated when SUB8_SAT_EN is defined).
- sign  output  1  equals c[7].
- overflow  output  1  signed overflow of a − b − borrow_in.
- borrow_out  output  1  unsigned borrow, i.e. a < b + borrow_in.

## Operation
- States: IDLE, SHIFT, DONE.
  - IDLE: start=1 captures a, b and borrow_in into the operand shift registers, sets the running borrow to borrow_in and the bit counter to 0, then moves to SHIFT. start=0 stays in IDLE.
  - SHIFT: each cycle computes d = a_i ^ b_i ^ br and br' = (~a_i & b_i) | (~(a_i ^ b_i) & br). d shifts into the internal difference register from the MSB side. After the counter reaches 7 the state moves to DONE.
  - DONE: commits the internal result to c, sign, overflow and borrow_out, then returns to IDLE on the next edge.
- Flags, from unsaturated raw values:
  - borrow_out is the final br.
  - overflow = (a[7] != b[7]) & (raw[7] != a[7]).
  - sign = c[7], evaluated after any saturation.
- Outputs c, sign, overflow and borrow_out update only on the DONE-entry edge. They hold until the next commit.
- start in SHIFT or DONE is ignored: not queued, no effect.
- Changes on a, b or borrow_in after capture have no effect on the operation in progress.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, c=0x00, sign=0, overflow=0, borrow_out=0; counter, operand and internal registers cleared.
- Reset asserted mid-operation: the operation is abandoned, the previous result is lost and all outputs go to their reset values. No done is produced.
- Latency: start accepted at edge N gives:
  - busy=1 from after edge N through edge N+8 (edges N+1..N+8 process bits 0..7);
  - done=1 and new results after edge N+8, for exactly one cycle;
  - busy=0 in the done cycle.
- Back-to-back: earliest next acceptance is edge N+10, with start high in the IDLE cycle after done. Throughput is one operation per 10 cycles.
- busy and done are never high together.

## Configuration
- SUB8_SAT_EN defined: on overflow, c saturates to 0x7F if a[7]=0, or 0x80 if a[7]=1. The overflow flag is still reported. sign follows the saturated c. borrow_out is unaffected.
- SUB8_SAT_EN undefined: c is the wrapped modulo-256 difference. The saturation mux is not synthesized.

## Test plan
- a=0x05, b=0x03, bin=0, start at edge N -> done after edge N+8; c=0x02, sign=0, overflow=0, borrow_out=0; busy high exactly 8 cycles.
- a=0x03, b=0x05, bin=0 -> c=0xFE, sign=1, overflow=0, borrow_out=1.
- a=0x80, b=0x01, bin=0 -> overflow=1, borrow_out=0. Without SUB8_SAT_EN: c=0x7F, sign=0. With SUB8_SAT_EN: c=0x80, sign=1.
- a=0x7F, b=0xFF, bin=0 -> overflow=1, borrow_out=1. Without macro: c=0x80, sign=1. With macro: c=0x7F, sign=0.
- a=0x00, b=0x00, bin=1 -> c=0xFF, sign=1, overflow=0, borrow_out=1.
- Pulse start again and change a/b at edge N+3 -> ignored; the first result is unchanged.
- Deassert rst_n at edge N+4 -> all outputs 0 immediately, no done pulse.
- After release, a new start completes normally in 8 cycles.

Source files
------------

// File: rtl/sub8_serial.sv
// Bit-serial 8-bit subtractor: a - b - borrow_in, LSB first, behind a start/done handshake.
// Optional SUB8_SAT_EN: saturate c to 0x7F/0x80 on signed overflow.
module sub8_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       borrow_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] c,
    output logic       sign,
    output logic       overflow,
    output logic       borrow_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     state;
    logic [7:0] a_sh;
    logic [7:0] b_sh;
    logic [7:0] diff;
    logic       br;
    logic [2:0] cnt;

    logic       d_bit;
    logic       br_next;
    logic [7:0] raw;
    logic       ovf_raw;
    logic [7:0] c_next;

    // Operands shift right, so on the final bit a_sh[0]/b_sh[0] hold the sign bits.
    always_comb begin
        d_bit   = a_sh[0] ^ b_sh[0] ^ br;
        br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
        raw     = {d_bit, diff[7:1]};
        ovf_raw = (a_sh[0] != b_sh[0]) & (raw[7] != a_sh[0]);
`ifdef SUB8_SAT_EN
        c_next  = ovf_raw ? (a_sh[0] ? 8'h80 : 8'h7F) : raw;
`else
        c_next  = raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_sh       <= 8'h00;
            b_sh       <= 8'h00;
            diff       <= 8'h00;
            br         <= 1'b0;
            cnt        <= 3'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            c          <= 8'h00;
            sign       <= 1'b0;
            overflow   <= 1'b0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        br    <= borrow_in;
                        diff  <= 8'h00;
                        cnt   <= 3'd0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    diff <= raw;
                    br   <= br_next;
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        c          <= c_next;
                        sign       <= c_next[7];
                        overflow   <= ovf_raw;
                        borrow_out <= br_next;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        a_sh <= {1'b0, a_sh[7:1]};
                        b_sh <= {1'b0, b_sh[7:1]};
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub8_serial.sv
// Scoreboard bench for sub8_serial: driver pushes arithmetic-model results, monitor checks on done.
module tb_sub8_serial;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       borrow_in = 1'b0;
    logic       busy, done, sign, overflow, borrow_out;
    logic [7:0] c;

    sub8_serial dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .borrow_in(borrow_in), .busy(busy), .done(done), .c(c),
        .sign(sign), .overflow(overflow), .borrow_out(borrow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] c;
        logic       s;
        logic       o;
        logic       bo;
        int         acc;
    } exp_t;

    exp_t exp_q[$];
    int   passed = 0;
    int   total  = 0;
    int   cyc    = 0;
    int   busy_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [7:0] ai, input logic [7:0] bi, input logic bin, input int acc);
        exp_t e;
        int ud, sd;
        ud = int'(ai) - int'(bi) - int'(bin);
        sd = int'($signed(ai)) - int'($signed(bi)) - int'(bin);
        e.bo  = (ud < 0);
        e.o   = (sd < -128) || (sd > 127);
        e.c   = ud[7:0];
`ifdef SUB8_SAT_EN
        if (e.o) e.c = ai[7] ? 8'h80 : 8'h7F;
`endif
        e.s   = e.c[7];
        e.acc = acc;
        return e;
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy && done) chk("busy_and_done", 1, 0);
            if (busy) busy_cnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("c", c, e.c);
                    chk("sign", sign, e.s);
                    chk("overflow", overflow, e.o);
                    chk("borrow_out", borrow_out, e.bo);
                    chk("latency", cyc - e.acc, 8);
                    chk("busy_cycles", busy_cnt, 8);
                end
                busy_cnt = 0;
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) begin
            chk("done_timeout", 0, 1);
            exp_q.delete();
        end
    endtask

    task automatic issue(input logic [7:0] ai, input logic [7:0] bi, input logic bin);
        @(negedge clk);
        a = ai; b = bi; borrow_in = bin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_q.push_back(model(ai, bi, bin, cyc));
    endtask

    task automatic run_op(input logic [7:0] ai, input logic [7:0] bi, input logic bin);
        issue(ai, bi, bin);
        wait_drain();
    endtask

    initial begin
        exp_t e0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_c", c, 0);
        chk("rst_flags", {sign, overflow, borrow_out}, 0);
        rst_n = 1'b1;

        run_op(8'h05, 8'h03, 1'b0);
        run_op(8'h03, 8'h05, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1);

        // Start pulse and operand changes mid-operation must be ignored.
        issue(8'h40, 8'hC0, 1'b0);
        e0 = model(8'h40, 8'hC0, 1'b0, 0);
        repeat (1) @(posedge clk);
        @(negedge clk);
        a = 8'h11; b = 8'h22; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_drain();
        repeat (12) @(negedge clk);
        chk("ignored_start_c", c, e0.c);
        chk("ignored_start_busy", busy, 0);

        // Reset in the middle of an operation.
        @(negedge clk);
        a = 8'h9A; b = 8'h17; borrow_in = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_c", c, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_flags", {sign, overflow, borrow_out}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_rst_c", c, 0);
        run_op(8'h9A, 8'h17, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            run_op(8'($urandom), 8'($urandom), 1'($urandom));
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
